// File: rtl/if_fetch_seq.sv
// if_fetch_seq: RV32IC fetch sequencer. Converts pc_i into I-cache word reads,
// realigns 16/32-bit instructions (including word-straddling 32-bit ones) and
// presents them on a valid/ready handshake.
// Optional macro IF_LINE_REUSE_EN: keep the line buffer valid across handshakes so
// one word read can serve two compressed instructions. Undefined: the buffer is
// invalidated on every handshake.
module if_fetch_seq #(
    parameter int unsigned PC_W     = 32,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] pc_i,
    input  logic            flush_i,
    input  logic            inst_ready_i,
    output logic            inst_valid_o,
    output logic [31:0]     inst_o,
    output logic            compressed_o,
    output logic            ic_read_o,
    output logic [PC_W-3:0] ic_addr_o,
    input  logic [31:0]     ic_rdata_i,
    input  logic            ic_stall_i
);

    typedef enum logic {StRun, StReq} state_e;

    state_e          r_state;
    logic            r_ic_read;
    logic [PC_W-3:0] r_ic_addr;
    logic [31:0]     r_buf_word;
    logic [PC_W-3:0] r_buf_addr;
    logic            r_buf_v;
    logic [15:0]     r_hi_hw;
    logic [PC_W-3:0] r_hi_addr;
    logic            r_hi_v;

    logic [PC_W-3:0] w_word;
    logic [PC_W-3:0] w_word_nxt;
    logic            w_hit;
    logic            w_strad_done;
    logic [15:0]     w_lo_hw;
    logic [15:0]     w_up_hw;
    logic            w_valid;
    logic [31:0]     w_inst;
    logic            w_comp;
    logic            w_need_hi;
    logic            w_miss;
    logic            w_unused;

    assign w_word       = pc_i[PC_W-1:2];
    assign w_word_nxt   = w_word + {{(PC_W-3){1'b0}}, 1'b1};
    assign w_hit        = r_buf_v && (r_buf_addr == w_word);
    // Upper half of a straddling instruction is sitting in the buffer, lower half in hold reg.
    assign w_strad_done = pc_i[1] && r_hi_v && (r_hi_addr == w_word) &&
                          r_buf_v && (r_buf_addr == w_word_nxt);
    assign w_lo_hw      = r_buf_word[15:0];
    assign w_up_hw      = r_buf_word[31:16];
    assign w_unused     = pc_i[0];

    // Decode what the buffered state can deliver for the current PC.
    always_comb begin
        w_valid   = 1'b0;
        w_inst    = NOP_INST;
        w_comp    = 1'b0;
        w_need_hi = 1'b0;
        w_miss    = 1'b0;
        if (r_state == StRun) begin
            if (w_strad_done) begin
                w_valid = 1'b1;
                w_inst  = {w_lo_hw, r_hi_hw};
            end else if (w_hit && !pc_i[1]) begin
                w_valid = 1'b1;
                if (w_lo_hw[1:0] != 2'b11) begin
                    w_comp = 1'b1;
                    w_inst = {16'h0000, w_lo_hw};
                end else begin
                    w_inst = r_buf_word;
                end
            end else if (w_hit && (w_up_hw[1:0] != 2'b11)) begin
                w_valid = 1'b1;
                w_comp  = 1'b1;
                w_inst  = {16'h0000, w_up_hw};
            end else if (w_hit) begin
                w_need_hi = 1'b1;
            end else begin
                w_miss = 1'b1;
            end
        end
        // A redirect suppresses delivery and any new read this cycle.
        if (flush_i) begin
            w_valid   = 1'b0;
            w_need_hi = 1'b0;
            w_miss    = 1'b0;
        end
    end

    assign inst_valid_o = w_valid;
    assign inst_o       = w_valid ? w_inst : NOP_INST;
    assign compressed_o = w_valid & w_comp;
    assign ic_read_o    = r_ic_read;
    assign ic_addr_o    = r_ic_addr;

    // Sequencer state, read request, line buffer and halfword hold register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= StRun;
            r_ic_read <= 1'b0;
            r_ic_addr <= '0;
            r_buf_v   <= 1'b0;
            r_hi_v    <= 1'b0;
        end else begin
            unique case (r_state)
                StRun: begin
                    if (w_need_hi) begin
                        r_hi_hw   <= w_up_hw;
                        r_hi_addr <= w_word;
                        r_hi_v    <= 1'b1;
                        r_ic_addr <= w_word_nxt;
                        r_ic_read <= 1'b1;
                        r_state   <= StReq;
                    end else if (w_miss) begin
                        r_ic_addr <= w_word;
                        r_ic_read <= 1'b1;
                        r_state   <= StReq;
                    end
`ifndef IF_LINE_REUSE_EN
                    if (w_valid && inst_ready_i) begin
                        r_buf_v <= 1'b0;
                    end
`endif
                end
                StReq: begin
                    if (!ic_stall_i) begin
                        r_buf_word <= ic_rdata_i;
                        r_buf_addr <= r_ic_addr;
                        r_buf_v    <= 1'b1;
                        r_ic_read  <= 1'b0;
                        r_state    <= StRun;
                    end
                end
            endcase
            if (flush_i) begin
                r_hi_v <= 1'b0;
            end
        end
    end

endmodule
